// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable sequence detector.
// Defaults reproduce the legacy fixed 1010 overlapping detector.
package seq_det_pkg;

    localparam int          PAT_W_MAX   = 16;
    localparam logic [15:0] DEF_PAT     = 16'h000A;
    localparam logic        DEF_OVL     = 1'b1;

    typedef enum logic {
        NON_OVL = 1'b0,
        OVL     = 1'b1
    } ovl_mode_e;

    typedef enum logic {
        FILLING,
        ARMED
    } arm_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a synchronous clear wins over a coincident increment.
// Used as the match counter of seq_det_prog.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_det_prog.sv
// Run-time programmable serial sequence detector with overlap control,
// input qualification and a saturating match counter.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = DEF_PAT[PAT_W-1:0],
    parameter logic             DEFAULT_OVL = DEF_OVL,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             in_valid,
    input  logic             cfg_wr,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_ovl,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] cfg_pattern_q
);

    localparam int             FW     = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL   = FW'(PAT_W);
    localparam logic [FW-1:0]  ARM_AT = FW'(PAT_W - 1);

    logic [PAT_W-1:0] pattern;
    ovl_mode_e        ovl;
    // Only the newest PAT_W-1 bits are kept; the full window is nxt.
    logic [PAT_W-2:0] hist;
    logic [PAT_W-1:0] nxt;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_d;
    arm_state_e       state;
    arm_state_e       state_d;
    logic             hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILLING;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        fill_d = fill;
        if (cfg_wr) begin
            fill_d = '0;
        end else if (in_valid) begin
            if (hit && (ovl == NON_OVL)) begin
                fill_d = '0;
            end else if (fill != FULL) begin
                fill_d = fill + FW'(1);
            end
        end
        state_d = (fill_d >= ARM_AT) ? ARMED : FILLING;
    end

    always_comb begin
        nxt = {hist, x};
        hit = (state == ARMED) && in_valid && !cfg_wr
              && (nxt == pattern);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= DEFAULT_PAT;
            ovl     <= ovl_mode_e'(DEFAULT_OVL);
            hist    <= '0;
            fill    <= '0;
            out     <= 1'b0;
        end else begin
            out  <= hit;
            fill <= fill_d;
            if (cfg_wr) begin
                pattern <= cfg_pattern;
                ovl     <= ovl_mode_e'(cfg_ovl);
                hist    <= '0;
            end else if (in_valid) begin
                hist <= nxt[PAT_W-2:0];
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (cnt_clr),
        .q   (match_cnt)
    );

    assign cfg_pattern_q = pattern;

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: table-driven vectors with a
// scoreboard queue, plus hand-written async reset sequences.
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       x;
    logic       in_valid;
    logic       cfg_wr;
    logic [3:0] cfg_pattern;
    logic       cfg_ovl;
    logic       cnt_clr;
    logic       out;
    logic       out2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic [3:0] pat_q;
    logic [3:0] pat_q2;

    always #5 clk = ~clk;

    seq_det_prog #(.PAT_W(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .x             (x),
        .in_valid      (in_valid),
        .cfg_wr        (cfg_wr),
        .cfg_pattern   (cfg_pattern),
        .cfg_ovl       (cfg_ovl),
        .cnt_clr       (cnt_clr),
        .out           (out),
        .match_cnt     (match_cnt),
        .cfg_pattern_q (pat_q)
    );

    seq_det_prog #(.PAT_W(4), .CNT_W(2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .x             (x),
        .in_valid      (in_valid),
        .cfg_wr        (cfg_wr),
        .cfg_pattern   (cfg_pattern),
        .cfg_ovl       (cfg_ovl),
        .cnt_clr       (cnt_clr),
        .out           (out2),
        .match_cnt     (match_cnt2),
        .cfg_pattern_q (pat_q2)
    );

    typedef struct {
        logic       x;
        logic       v;
        logic       wr;
        logic [3:0] pat;
        logic       ovl;
        logic       clr;
        logic       eo;
    } vec_t;

    typedef struct {
        logic       out;
        logic [7:0] c8;
        logic [1:0] c2;
        logic [3:0] pat;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    int         total  = 0;
    int         passed = 0;
    logic [7:0] m8;
    logic [1:0] m2;
    logic [3:0] mpat;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void add1(input logic xv, input logic v,
                                 input logic wr, input logic [3:0] pat,
                                 input logic ovl, input logic clr,
                                 input logic eo);
        vec_t r;
        r = '{xv, v, wr, pat, ovl, clr, eo};
        vecs.push_back(r);
    endfunction

    function automatic void add_bits(input logic [15:0] b, input int n,
                                     input logic [15:0] e);
        for (int i = n - 1; i >= 0; i--)
            add1(b[i], 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, e[i]);
    endfunction

    function automatic void add_cfg(input logic [3:0] pat, input logic ovl);
        add1(1'b0, 1'b0, 1'b1, pat, ovl, 1'b0, 1'b0);
    endfunction

    task automatic model_reset();
        m8   = 8'd0;
        m2   = 2'd0;
        mpat = 4'b1010;
    endtask

    task automatic step(input vec_t v, input int idx);
        exp_t e;
        x           = v.x;
        in_valid    = v.v;
        cfg_wr      = v.wr;
        cfg_pattern = v.pat;
        cfg_ovl     = v.ovl;
        cnt_clr     = v.clr;
        if (v.wr) mpat = v.pat;
        if (v.clr) begin
            m8 = 8'd0;
            m2 = 2'd0;
        end else if (v.eo) begin
            if (m8 != 8'hFF) m8 = m8 + 8'd1;
            if (m2 != 2'd3)  m2 = m2 + 2'd1;
        end
        e = '{v.eo, m8, m2, mpat};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("out[%0d]", idx), 32'(out), 32'(e.out));
        chk($sformatf("out2[%0d]", idx), 32'(out2), 32'(e.out));
        chk($sformatf("cnt[%0d]", idx), 32'(match_cnt), 32'(e.c8));
        chk($sformatf("cnt2[%0d]", idx), 32'(match_cnt2), 32'(e.c2));
        chk($sformatf("pat[%0d]", idx), 32'(pat_q), 32'(e.pat));
    endtask

    task automatic apply(input string tag);
        foreach (vecs[i]) step(vecs[i], i);
        vecs.delete();
        if (sb.size() != 0) chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_out"}, 32'(out), 32'd0);
        chk({name, "_out2"}, 32'(out2), 32'd0);
        chk({name, "_cnt"}, 32'(match_cnt), 32'd0);
        chk({name, "_cnt2"}, 32'(match_cnt2), 32'd0);
        chk({name, "_pat"}, 32'(pat_q), 32'hA);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        x           = 1'b0;
        in_valid    = 1'b0;
        cfg_wr      = 1'b0;
        cfg_pattern = 4'h0;
        cfg_ovl     = 1'b0;
        cnt_clr     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        // default pattern, single match
        add_bits(16'hA, 4, 16'h1);
        // overlapping 8-bit stream
        add_cfg(4'b1010, 1'b1);
        add_bits(16'hAA, 8, 16'b0001_0101);
        // non-overlapping 8-bit stream
        add_cfg(4'b1010, 1'b0);
        add_bits(16'hAA, 8, 16'b0001_0001);
        // qualification gaps
        add1(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) add1(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        add1(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) add1(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        add1(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) add1(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        add1(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        add1(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        // cfg_wr with a coincident valid bit that must be dropped
        add1(1'b1, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0, 1'b0);
        add_bits(16'b101, 3, 16'h0);
        add_bits(16'b1101, 4, 16'h1);
        // counter clear, all-ones overlap, saturation, clr vs match
        add1(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        add_cfg(4'b1111, 1'b1);
        add_bits(16'hFF, 8, 16'b0001_1111);
        add1(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        add_bits(16'h1, 1, 16'h1);
        // all-ones non-overlap
        add_cfg(4'b1111, 1'b0);
        add_bits(16'hFF, 8, 16'b0001_0001);
        apply("table");

        // reset while a match pulse is visible
        add_cfg(4'b1010, 1'b1);
        add_bits(16'hA, 4, 16'h1);
        apply("pre_rst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_idle("rst_inflight");
        @(posedge clk);
        #1;
        check_idle("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        // reset in the middle of a partial match
        add_bits(16'b101, 3, 16'h0);
        apply("partial");
        #2 rst = 1'b1;
        #1;
        check_idle("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        add_bits(16'h0, 1, 16'h0);
        add_bits(16'hA, 4, 16'h1);
        apply("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
